// File: rtl/udp_rx_path.sv
// udp_rx_path: receive-side UDP datagram filter and byte-to-word packer.
// Accepts a UDP header, then either packs the payload little-endian into
// DATA_W-bit words (first byte in bits 7:0) or discards it. Exposes the
// sender's address and wrapping delivered/dropped datagram counters.
// Optional feature: define UDP_RX_FILTER_EN to accept only datagrams sent to
// local_port at local_ip or the broadcast address 255.255.255.255.

module udp_rx_path #(
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_udp_hdr_valid,
    output logic                  rx_udp_hdr_ready,
    input  logic [31:0]           rx_udp_ip_source_ip,
    input  logic [31:0]           rx_udp_ip_dest_ip,
    input  logic [15:0]           rx_udp_source_port,
    input  logic [15:0]           rx_udp_dest_port,
    input  logic [15:0]           rx_udp_length,
    input  logic [7:0]            rx_udp_payload_axis_tdata,
    input  logic                  rx_udp_payload_axis_tvalid,
    output logic                  rx_udp_payload_axis_tready,
    input  logic                  rx_udp_payload_axis_tlast,
    input  logic                  rx_udp_payload_axis_tuser,
    input  logic [31:0]           local_ip,
    input  logic [15:0]           local_port,
    output logic [DATA_W-1:0]     dout_data,
    output logic [DATA_W/8-1:0]   dout_keep,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_last,
    output logic                  dout_error,
    output logic [31:0]           pkt_src_ip,
    output logic [15:0]           pkt_src_port,
    output logic [15:0]           rx_pkt_count,
    output logic [15:0]           rx_drop_count
);

    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        DROP
    } state_t;

    state_t             state;
    logic [DATA_W-1:0]  acc;
    logic [IDX_W-1:0]   idx;
    logic [15:0]        byte_cnt;
    logic [15:0]        expected;

    logic               hdr_accept;
    logic               byte_accept;
    logic               dout_take;
    logic               filter_pass;
    logic               word_done;
    logic               pkt_bad;
    logic [16:0]        cnt_plus;
    logic [DATA_W-1:0]  acc_next;
    logic [BYTES-1:0]   keep_next;

    // Handshake readies: header only in IDLE with the output register free,
    // payload in PAYLOAD when the output register can take a word, always in DROP.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        rx_udp_hdr_ready           = 1'b0;
        rx_udp_payload_axis_tready = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    rx_udp_hdr_ready           = !dout_valid;
                PAYLOAD: rx_udp_payload_axis_tready = !dout_valid || dout_ready;
                DROP:    rx_udp_payload_axis_tready = 1'b1;
                default: ;
            endcase
        end
    end

    assign hdr_accept  = rx_udp_hdr_valid && rx_udp_hdr_ready;
    assign byte_accept = rx_udp_payload_axis_tvalid && rx_udp_payload_axis_tready;
    assign dout_take   = dout_valid && dout_ready;

`ifdef UDP_RX_FILTER_EN
    // Destination filter: our port, addressed to us or to broadcast.
    always_comb begin
        filter_pass = (rx_udp_dest_port == local_port) &&
                      ((rx_udp_ip_dest_ip == local_ip) || (rx_udp_ip_dest_ip == 32'hFFFF_FFFF));
    end
`else
    // No destination filter: only the length rule can reject a datagram.
    always_comb begin
        filter_pass = 1'b1;
    end

    logic unused_filter_inputs;
    assign unused_filter_inputs = ^{local_ip, local_port, rx_udp_ip_dest_ip, rx_udp_dest_port};
`endif

    // Accumulator with the incoming byte merged into lane idx, and the keep
    // mask covering lanes 0..idx; upper lanes keep stale contents.
    always_comb begin
        acc_next = acc;
        acc_next[int'(idx)*8 +: 8] = rx_udp_payload_axis_tdata;
        for (int i = 0; i < BYTES; i++) begin
            keep_next[i] = (i <= int'(idx));
        end
    end

    assign word_done = (idx == IDX_W'(BYTES - 1)) || rx_udp_payload_axis_tlast;

    // 17-bit compare: once byte_cnt saturates at 0xFFFF, cnt_plus is 0x10000,
    // which can never equal a 16-bit expected count, so overflow reads as bad.
    assign cnt_plus = {1'b0, byte_cnt} + 17'd1;
    assign pkt_bad  = rx_udp_payload_axis_tuser || (cnt_plus != {1'b0, expected});

    // Receive FSM with header latching, byte packing and the output word register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= '0;
            idx          <= '0;
            byte_cnt     <= '0;
            expected     <= '0;
            dout_data    <= '0;
            dout_keep    <= '0;
            dout_valid   <= 1'b0;
            dout_last    <= 1'b0;
            dout_error   <= 1'b0;
            pkt_src_ip   <= '0;
            pkt_src_port <= '0;
        end else begin
            // NOTE: non-blocking assignments; a later assignment in this block wins, so a new word overrides the drain.
            if (dout_take) begin
                dout_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (hdr_accept) begin
                        pkt_src_ip   <= rx_udp_ip_source_ip;
                        pkt_src_port <= rx_udp_source_port;
                        expected     <= rx_udp_length - 16'd8;
                        byte_cnt     <= '0;
                        idx          <= '0;
                        if ((rx_udp_length < 16'd9) || !filter_pass) begin
                            state <= DROP;
                        end else begin
                            state <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (byte_accept) begin
                        acc      <= acc_next;
                        idx      <= idx + IDX_W'(1);
                        byte_cnt <= (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
                        if (word_done) begin
                            dout_data  <= acc_next;
                            dout_keep  <= keep_next;
                            dout_valid <= 1'b1;
                            dout_last  <= rx_udp_payload_axis_tlast;
                            dout_error <= rx_udp_payload_axis_tlast && pkt_bad;
                            idx        <= '0;
                            if (rx_udp_payload_axis_tlast) begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                DROP: begin
                    if (byte_accept && rx_udp_payload_axis_tlast) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Wrapping statistics: delivered on the final word handshake, dropped on the discarded tlast.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_pkt_count  <= '0;
            rx_drop_count <= '0;
        end else begin
            if (dout_take && dout_last) begin
                rx_pkt_count <= rx_pkt_count + 16'd1;
            end
            if ((state == DROP) && byte_accept && rx_udp_payload_axis_tlast) begin
                rx_drop_count <= rx_drop_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_udp_rx_path.sv
// tb_udp_rx_path: randomized scoreboard bench for udp_rx_path (DATA_W = 64).
// Honours UDP_RX_FILTER_EN in its reference model when the macro is defined.

module tb_udp_rx_path;

    localparam int          DATA_W     = 64;
    localparam int          BYTES      = DATA_W / 8;
    localparam int          BUDGET     = 400;
    localparam logic [31:0] LOCAL_IP   = 32'hC0A8_0001;
    localparam logic [15:0] LOCAL_PORT = 16'd5000;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               hdr_valid = 1'b0;
    logic               hdr_ready;
    logic [31:0]        h_sip = '0, h_dip = '0;
    logic [15:0]        h_sport = '0, h_dport = '0, h_len = '0;
    logic [7:0]         tdata = '0;
    logic               tvalid = 1'b0, tready, tlast = 1'b0, tuser = 1'b0;
    logic [DATA_W-1:0]  dout_data;
    logic [BYTES-1:0]   dout_keep;
    logic               dout_valid, dout_ready, dout_last, dout_error;
    logic [31:0]        pkt_src_ip;
    logic [15:0]        pkt_src_port, rx_pkt_count, rx_drop_count;

    udp_rx_path #(.DATA_W(DATA_W)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .rx_udp_hdr_valid           (hdr_valid),
        .rx_udp_hdr_ready           (hdr_ready),
        .rx_udp_ip_source_ip        (h_sip),
        .rx_udp_ip_dest_ip          (h_dip),
        .rx_udp_source_port         (h_sport),
        .rx_udp_dest_port           (h_dport),
        .rx_udp_length              (h_len),
        .rx_udp_payload_axis_tdata  (tdata),
        .rx_udp_payload_axis_tvalid (tvalid),
        .rx_udp_payload_axis_tready (tready),
        .rx_udp_payload_axis_tlast  (tlast),
        .rx_udp_payload_axis_tuser  (tuser),
        .local_ip                   (LOCAL_IP),
        .local_port                 (LOCAL_PORT),
        .dout_data                  (dout_data),
        .dout_keep                  (dout_keep),
        .dout_valid                 (dout_valid),
        .dout_ready                 (dout_ready),
        .dout_last                  (dout_last),
        .dout_error                 (dout_error),
        .pkt_src_ip                 (pkt_src_ip),
        .pkt_src_port               (pkt_src_port),
        .rx_pkt_count               (rx_pkt_count),
        .rx_drop_count              (rx_drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [BYTES-1:0]  keep;
        logic              last;
        logic              err;
        logic [31:0]       sip;
        logic [15:0]       sport;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  pl[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_pkt = 0;
    int          exp_drop = 0;
    int          ready_mode = 0;  // 0: always ready, 1: random, 2: held low
    bit          gap_mode = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic abort(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: wait budget expired at %0t", name, $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    endtask

    // Application-side ready pattern, changed just after each rising edge.
    initial begin
        dout_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       dout_ready = 1'b1;
                1:       dout_ready = ($urandom_range(0, 3) != 0);
                default: dout_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on each output handshake and checks hold stability.
    logic              have_hold = 1'b0;
    logic [DATA_W-1:0] hold_data;
    logic [BYTES-1:0]  hold_keep;
    logic              hold_last, hold_err;
    initial begin
        exp_t        e;
        logic [DATA_W-1:0] mask;
        forever begin
            @(negedge clk);
            if (rst) begin
                have_hold = 1'b0;
            end else begin
                if (have_hold) begin
                    check("hold_data", dout_data, hold_data);
                    check("hold_flags", {dout_valid, dout_keep, dout_last, dout_error},
                          {1'b1, hold_keep, hold_last, hold_err});
                end
                have_hold = dout_valid && !dout_ready;
                hold_data = dout_data;
                hold_keep = dout_keep;
                hold_last = dout_last;
                hold_err  = dout_error;
                if (dout_valid && dout_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_word", {dout_valid, dout_data}, '0);
                    end else begin
                        e = sb.pop_front();
                        mask = '0;
                        for (int b = 0; b < BYTES; b++) if (e.keep[b]) mask[b*8 +: 8] = 8'hFF;
                        check("word_data", dout_data & mask, e.data);
                        check("word_keep", dout_keep, e.keep);
                        check("word_last", dout_last, e.last);
                        if (e.last) check("word_error", dout_error, e.err);
                        check("word_src", {pkt_src_ip, pkt_src_port}, {e.sip, e.sport});
                    end
                end
            end
        end
    end

    task automatic send_hdr(input logic [31:0] sip, dip, input logic [15:0] sport, dport, len);
        int n = 0;
        h_sip = sip; h_dip = dip; h_sport = sport; h_dport = dport; h_len = len;
        hdr_valid = 1'b1;
        @(negedge clk);
        while (!hdr_ready && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (!hdr_ready) abort("hdr_ready_timeout");
        @(posedge clk);
        #1;
        hdr_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit last, input bit user);
        int n = 0;
        if (gap_mode) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        tdata = d; tlast = last; tuser = user; tvalid = 1'b1;
        @(negedge clk);
        while (!tready && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (!tready) abort("tready_timeout");
        @(posedge clk);
        #1;
        tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
    endtask

    // Reference model: deliver when length >= 9 and the destination is accepted;
    // chop the payload into BYTES-sized words; error on tuser or byte count mismatch.
    task automatic send_datagram(input logic [31:0] sip, dip, input logic [15:0] sport, dport, len,
                                 input bit user);
        int   n = pl.size();
        bit   pass;
        exp_t e;
`ifdef UDP_RX_FILTER_EN
        pass = (dport == LOCAL_PORT) && (dip == LOCAL_IP || dip == 32'hFFFF_FFFF);
`else
        pass = 1'b1;
`endif
        if (len >= 16'd9 && pass) begin
            exp_pkt++;
            for (int w = 0; w * BYTES < n; w++) begin
                e.data = '0;
                e.keep = '0;
                for (int b = 0; b < BYTES && w * BYTES + b < n; b++) begin
                    e.data[b*8 +: 8] = pl[w * BYTES + b];
                    e.keep[b] = 1'b1;
                end
                e.last  = ((w + 1) * BYTES >= n);
                e.err   = e.last && (user || (n != int'(len) - 8));
                e.sip   = sip;
                e.sport = sport;
                sb.push_back(e);
            end
        end else begin
            exp_drop++;
        end
        send_hdr(sip, dip, sport, dport, len);
        for (int i = 0; i < n; i++) send_byte(pl[i], i == n - 1, user && (i == n - 1));
    endtask

    task automatic fill(input int n, input logic [7:0] base);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(base + 8'(i));
    endtask

    task automatic drain_and_count(input string tag);
        int n = 0;
        while ((sb.size() != 0 || dout_valid) && n < 4 * BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || dout_valid) abort("drain_timeout");
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_pkt_count"}, rx_pkt_count, 16'(exp_pkt));
        check({tag, "_drop_count"}, rx_drop_count, 16'(exp_drop));
    endtask

    initial begin
        #200_000_000;
        abort("global_watchdog");
    end

    initial begin
        logic [31:0] sip, dip;
        logic [15:0] sport, dport, len;
        int          n, sel;
        bit          user;

        // Reset state.
        @(negedge clk);
        check("rst_hdr_ready", hdr_ready, 1'b0);
        check("rst_tready", tready, 1'b0);
        check("rst_outputs", {dout_valid, dout_last, dout_error, dout_keep, dout_data}, '0);
        check("rst_regs", {pkt_src_ip, pkt_src_port, rx_pkt_count, rx_drop_count}, '0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_hdr_ready", hdr_ready, 1'b1);

        // Payload offered in IDLE is not accepted.
        tvalid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_tready", tready, 1'b0);
        end
        tvalid = 1'b0;
        @(posedge clk);
        #1;

        // Two full words.
        fill(16, 8'h00);
        send_datagram(32'h0A00_0001, LOCAL_IP, 16'd1234, LOCAL_PORT, 16'd24, 1'b0);
        drain_and_count("two_words");

        // Single partial word.
        fill(5, 8'hA1);
        send_datagram(32'h0A00_0002, LOCAL_IP, 16'd1235, LOCAL_PORT, 16'd13, 1'b0);
        drain_and_count("partial");

        // Early tlast: length says 16, only 10 bytes arrive.
        fill(10, 8'h30);
        send_datagram(32'h0A00_0003, 32'hFFFF_FFFF, 16'd77, LOCAL_PORT, 16'd24, 1'b0);
        drain_and_count("short");

        // Wrong destination port (dropped only when filtering).
        fill(20, 8'h50);
        send_datagram(32'h0A00_0004, LOCAL_IP, 16'd88, LOCAL_PORT + 16'd1, 16'd28, 1'b0);
        drain_and_count("port");

        // Length below 9 always drops.
        fill(1, 8'hEE);
        send_datagram(32'h0A00_0005, LOCAL_IP, 16'd89, LOCAL_PORT, 16'd8, 1'b0);
        drain_and_count("short_len");

        // Core-flagged bad frame.
        fill(9, 8'h60);
        send_datagram(32'h0A00_0006, LOCAL_IP, 16'd90, LOCAL_PORT, 16'd17, 1'b1);
        drain_and_count("tuser");

        // Output stall mid-datagram.
        ready_mode = 2;
        fill(24, 8'h80);
        fork
            send_datagram(32'h0A00_0007, LOCAL_IP, 16'd91, LOCAL_PORT, 16'd32, 1'b0);
            begin
                repeat (30) @(negedge clk);
                check("stall_tready", tready, 1'b0);
                check("stall_valid", dout_valid, 1'b1);
                check("stall_hdr_ready", hdr_ready, 1'b0);
                ready_mode = 0;
            end
        join
        drain_and_count("stall");

        // Second header refused while the previous last word is pending.
        ready_mode = 2;
        fill(5, 8'hC0);
        send_datagram(32'h0A00_0008, LOCAL_IP, 16'd92, LOCAL_PORT, 16'd13, 1'b0);
        fill(7, 8'hD0);
        fork
            send_datagram(32'h0A00_0009, LOCAL_IP, 16'd93, LOCAL_PORT, 16'd15, 1'b0);
            begin
                repeat (10) begin
                    @(negedge clk);
                    check("pending_hdr_ready", hdr_ready, 1'b0);
                end
                ready_mode = 0;
            end
        join
        drain_and_count("refuse");

        // Reset during byte 5 of a datagram.
        send_hdr(32'h0A00_000A, LOCAL_IP, 16'd94, LOCAL_PORT, 16'd20);
        for (int i = 0; i < 4; i++) send_byte(8'hF0 + 8'(i), 1'b0, 1'b0);
        tdata = 8'hF4; tvalid = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ready", {hdr_ready, tready}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        tvalid = 1'b0;
        exp_pkt = 0;
        exp_drop = 0;
        @(negedge clk);
        check("midrst_hdr_ready", hdr_ready, 1'b1);
        check("midrst_outputs", {dout_valid, dout_last, dout_error, dout_keep, dout_data}, '0);
        check("midrst_regs", {pkt_src_ip, pkt_src_port, rx_pkt_count, rx_drop_count}, '0);
        @(posedge clk);
        #1;
        fill(11, 8'h10);
        send_datagram(32'h0A00_000B, LOCAL_IP, 16'd95, LOCAL_PORT, 16'd19, 1'b0);
        drain_and_count("after_rst");

        // Randomized traffic with random gaps and back-pressure.
        ready_mode = 1;
        gap_mode = 1;
        for (int k = 0; k < 16; k++) begin
            n = $urandom_range(1, 40);
            sel = $urandom_range(0, 5);
            len = 16'(8 + n);
            if (sel == 0) len = 16'(8 + n + 3);
            if (sel == 1) len = 16'(8 + n - 1);
            user = ($urandom_range(0, 7) == 0);
            sip = $urandom;
            sport = 16'($urandom);
            case ($urandom_range(0, 3))
                0, 1:    dip = LOCAL_IP;
                2:       dip = 32'hFFFF_FFFF;
                default: dip = 32'h0B00_0000 | 32'($urandom_range(0, 255));
            endcase
            dport = ($urandom_range(0, 4) == 0) ? LOCAL_PORT + 16'd7 : LOCAL_PORT;
            pl.delete();
            for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
            send_datagram(sip, dip, sport, dport, len, user);
        end
        ready_mode = 0;
        gap_mode = 0;
        drain_and_count("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
